// File: rtl/adder_share_arb_pkg.sv
// Shared types and constants for the time-shared adder arbiter.
package adder_share_arb_pkg;
  localparam int ADDER_W = 16;
  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/adder_16bit_b.sv
// 16-bit add/subtract datapath with carry-out and signed overflow.
module adder_16bit_b
  import adder_share_arb_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        add_ctrl,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        ovf
);
  logic [15:0] b_eff;

  // Subtract is A + ~B + 1, so c_out = 1 means no borrow.
  assign b_eff = (add_ctrl == ADD) ? b : ~b;
  assign {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + {16'd0, (add_ctrl != ADD)};
  assign ovf = (a[15] == b_eff[15]) && (sum[15] != a[15]);
endmodule

// File: rtl/adder_share_arb_rr_pick.sv
// Round-robin one-hot pick: first valid bit scanning upward from ptr, with wrap.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  id,
  output logic             any
);
  int idx;

  // Scan from the far end so the candidate nearest ptr is written last and wins.
  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_share_arb.sv
// Shares one adder_16bit_b among N_REQ requesters; round-robin grant, one op per 3 cycles.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_add_ctrl,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_ovf,
  output state_t                 dbg_state
);
  if (WIDTH != ADDER_W || N_REQ < 2 || N_REQ > 8 || ID_W != $clog2(N_REQ)) begin : g_bad_cfg
    $error("adder_share_arb: unsupported WIDTH/N_REQ/ID_W combination");
  end

  state_t           state;
  logic             rst_s0, rst_s1;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gnt_id, id_q, rr_ptr;
  logic             gnt_any;
  logic [WIDTH-1:0] a_sel, b_sel, a_q, b_q, sum;
  logic             ctrl_sel, ctrl_q, cout, ovf;

  // Reset asserts asynchronously; grants resume only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rst_s1, rst_s0} <= 2'b00;
    else        {rst_s1, rst_s0} <= {rst_s0, 1'b1};
  end

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .id    (gnt_id),
    .any   (gnt_any)
  );

  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    ctrl_sel = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel    = req_a[i*WIDTH +: WIDTH];
        b_sel    = req_b[i*WIDTH +: WIDTH];
        ctrl_sel = req_add_ctrl[i];
      end
    end
  end

  assign req_ready = (state == IDLE && rst_s1) ? grant : '0;
  assign dbg_state = state;

  adder_16bit_b u_add (
    .a        (a_q),
    .b        (b_q),
    .add_ctrl (ctrl_q),
    .sum      (sum),
    .c_out    (cout),
    .ovf      (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any && rst_s1) begin
            a_q    <= a_sel;
            b_q    <= b_sel;
            ctrl_q <= ctrl_sel;
            id_q   <= gnt_id;
            rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= sum;
          rsp_cout  <= cout;
          rsp_ovf   <= ovf;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arb.sv
// Randomised scoreboard bench for adder_share_arb with directed corner cases.
module tb_adder_share_arb;
  import adder_share_arb_pkg::*;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] req_a, req_b;
  logic [N-1:0]  req_add_ctrl;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_sum;
  logic          rsp_cout, rsp_ovf;
  state_t        dbg_state;

  logic [15:0] op_a [N];
  logic [15:0] op_b [N];
  logic        op_c [N];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int resp_count = 0;
  int n_grants   = 0;
  int model_ptr  = 0;
  logic [19:0] exp_q [$];
  int          gcyc_q [$];
  int          grant_log [$];
  logic [N-1:0] gnt_last = '0;
  logic [19:0]  last_rsp = '0;
  logic [19:0]  prev_out = '0;
  logic         prev_valid = 1'b0, prev_ready = 1'b0;

  adder_share_arb #(.WIDTH(16), .N_REQ(N), .ID_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_add_ctrl (req_add_ctrl),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_cout     (rsp_cout),
    .rsp_ovf      (rsp_ovf),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16]  = op_a[i];
      req_b[i*16 +: 16]  = op_b[i];
      req_add_ctrl[i]    = op_c[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic on plain integers: {ovf, cout, sum}.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    int ua, ub, sa, sb, r, s;
    logic [31:0] rv;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (c == ADD) begin
      r = ua + ub;
      s = sa + sb;
    end else begin
      r = ua - ub + 65536;
      s = sa - sb;
    end
    rv = r;
    return {(s > 32767 || s < -32768), (r >= 65536), rv[15:0]};
  endfunction

  function automatic int rr_model(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // grant observer: predicts the winner and pushes the expected response
  always @(negedge clk) begin
    logic [1:0] pid;
    int p;
    gnt_last = '0;
    if (rst_n && req_ready != '0) begin
      p = rr_model(req_valid, model_ptr);
      chk("grant_onehot", 32'(req_ready), (p < 0) ? 32'hFFFF_FFFF : (32'd1 << p));
      if (p >= 0) begin
        pid = 2'(p);
        exp_q.push_back({pid, ref_op(op_a[p], op_b[p], op_c[p])});
        gcyc_q.push_back(cyc);
        grant_log.push_back(p);
        model_ptr = (p + 1) % N;
        n_grants++;
      end
      gnt_last = req_ready;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [19:0] act, e;
    int g;
    act = {rsp_id, rsp_ovf, rsp_cout, rsp_sum};
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (rsp_valid) chk("ready_while_resp", 32'(req_ready), 32'd0);
      if (rsp_valid && !prev_valid) begin
        if (gcyc_q.size() == 0) chk("unexpected_rsp_valid", 32'd1, 32'd0);
        else begin
          g = gcyc_q.pop_front();
          chk("latency", 32'(cyc - g), 32'd2);
        end
      end
      if (prev_valid && !prev_ready) chk("rsp_hold", {11'd0, rsp_valid, act}, {11'd0, 1'b1, prev_out});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("result", 32'(act), 32'(e));
        end
        last_rsp = act;
        resp_count++;
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_out   = act;
    end
  end

  // driver tasks
  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    bit got;
    @(posedge clk); #1;
    op_a[i] = a; op_b[i] = b; op_c[i] = c;
    req_valid[i] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int t = 0; t < 200 && resp_count < target; t++) @(negedge clk);
    if (resp_count < target) chk("resp_timeout", 32'(resp_count), 32'(target));
  endtask

  task automatic expect_last(input string name, input logic [1:0] id, input logic [15:0] s,
                             input logic co, input logic ov);
    chk(name, 32'(last_rsp), 32'({id, ov, co, s}));
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {dbg_state, req_ready, rsp_valid, rsp_id, rsp_ovf, rsp_cout, rsp_sum},
        {IDLE, 4'b0, 1'b0, 2'b0, 1'b0, 1'b0, 16'h0});
  endtask

  task automatic flush_model();
    exp_q.delete();
    gcyc_q.delete();
    model_ptr = 0;
  endtask

  initial begin
    int base, t;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; op_c[i] = ADD; end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    // boundary adds/subtracts on individual requesters
    issue(0, 16'h7FFF, 16'h0001, ADD);
    wait_resp(1);
    expect_last("r0_add_ovf", 2'd0, 16'h8000, 1'b0, 1'b1);
    issue(1, 16'h0000, 16'h0001, SUB);
    wait_resp(2);
    expect_last("r1_sub_borrow", 2'd1, 16'hFFFF, 1'b0, 1'b0);
    issue(2, 16'h8000, 16'h0001, SUB);
    wait_resp(3);
    expect_last("r2_sub_ovf", 2'd2, 16'h7FFF, 1'b1, 1'b1);

    // all requesters held valid out of reset: order 0,1,2,3,0
    @(negedge clk);
    rst_n = 1'b0;
    flush_model();
    op_a[0] = 16'hFFFF; op_b[0] = 16'h0001; op_c[0] = ADD;
    op_a[1] = 16'h1234; op_b[1] = 16'h4321; op_c[1] = ADD;
    op_a[2] = 16'h0005; op_b[2] = 16'h0007; op_c[2] = SUB;
    op_a[3] = 16'h7FFF; op_b[3] = 16'hFFFF; op_c[3] = SUB;
    req_valid = 4'hF;
    @(negedge clk);
    check_reset_outputs("reset_with_valid");
    rst_n = 1'b1;
    base = n_grants;
    grant_log.delete();
    for (t = 0; t < 100 && n_grants < base + 5; t++) @(negedge clk);
    chk("rr_grant_count", 32'(n_grants - base), 32'd5);
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(resp_count + 1);
    expect_last("rr_first_wrap", 2'd0, 16'h0000, 1'b1, 1'b0);
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++) chk("rr_order", 32'(grant_log[k]), 32'(k % N));
    else chk("rr_order_len", 32'(grant_log.size()), 32'd5);
    for (t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);

    // back-pressure: result held, no new grant while in RESP
    rsp_ready = 1'b0;
    issue(3, 16'h4000, 16'h4000, ADD);
    op_a[1] = 16'h0002; op_b[1] = 16'h0003; op_c[1] = SUB;
    req_valid[1] = 1'b1;
    for (t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
    base = n_grants;
    repeat (5) @(negedge clk);
    chk("bp_no_grant", 32'(n_grants - base), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    expect_last("bp_second", 2'd1, 16'hFFFF, 1'b0, 1'b0);

    // reset while EXEC: op dropped, outputs cleared immediately
    base = resp_count;
    issue(2, 16'h1111, 16'h2222, ADD);
    chk("in_exec", 32'(dbg_state), 32'(EXEC));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_exec");
    flush_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 16'h0F0F, 16'h00F1, SUB);
    wait_resp(base + 1);
    expect_last("after_reset", 2'd0, 16'h0E1E, 1'b1, 1'b0);
    chk("dropped_op_absent", 32'(resp_count - base), 32'd1);

    // randomized traffic with random back-pressure and withdrawals
    base = resp_count;
    for (t = 0; t < 80000 && resp_count < base + 10000; t++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < N; i++) begin
        if (gnt_last[i] || (req_valid[i] && $urandom_range(0, 15) == 0)) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          op_a[i] = rnd16(); op_b[i] = rnd16(); op_c[i] = 1'($urandom_range(0, 1));
        end else if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
          req_valid[i] = 1'b1;
          op_a[i] = rnd16(); op_b[i] = rnd16(); op_c[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    chk("random_count", 32'(resp_count - base >= 10000), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
